// File: rtl/aes128_pkg.sv
// -----------------------------------------------------------------------------
// aes128_pkg
// Shared definitions for the AES-128 block-mode controllers: block/key widths,
// the block word type and the CBC sequencing state encoding. The state enum is
// kept here so that a decryption controller can reuse the same encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package aes128_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 128;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [2:0] {
        IDLE,
        KEY_LOAD,
        KEY_WAIT,
        GET_PT,
        CORE_RUN,
        CORE_WAIT,
        PUT_CT,
        FINISH
    } cbc_state_t;

endpackage : aes128_pkg

// File: rtl/aes128_cbc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// aes128_cbc_seq_ctrl
// CBC-mode sequencer for a multi-cycle AES-128 encryption core. A start pulse
// captures key, IV and block count; the core is asked to expand the key, then
// each plaintext block is XORed with the chaining value, encrypted, returned on
// the ciphertext stream and fed back as the next chaining value. At most one
// block is in flight, so ciphertext backpressure stalls everything upstream.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cfg_start/key/iv/num    message configuration, accepted in IDLE only
//   busy, done              message in progress / one-cycle completion pulse
//   pt_data/valid/ready     plaintext input stream
//   ct_data/valid/ready/last ciphertext output stream, last marks final block
//   core_key/key_load/key_ready  key hand-off to the core
//   core_start/block/done/result one block encryption on the core
// -----------------------------------------------------------------------------
module aes128_cbc_seq_ctrl
    import aes128_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int BLK_W = AES_BLK_W
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             cfg_start,
    input  logic [BLK_W-1:0] cfg_key,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic [CNT_W-1:0] cfg_num_blocks,
    output logic             busy,
    output logic             done,

    input  logic [BLK_W-1:0] pt_data,
    input  logic             pt_valid,
    output logic             pt_ready,

    output logic [BLK_W-1:0] ct_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic             ct_last,

    output logic [BLK_W-1:0] core_key,
    output logic             core_key_load,
    input  logic             core_key_ready,
    output logic             core_start,
    output logic [BLK_W-1:0] core_block,
    input  logic             core_done,
    input  logic [BLK_W-1:0] core_result
);

    cbc_state_t       state_q, state_d;

    logic [BLK_W-1:0] key_q;
    logic [BLK_W-1:0] chain_q;
    logic [BLK_W-1:0] block_q;
    logic [BLK_W-1:0] ct_data_q;
    logic             ct_last_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_q;

    // Qualified events; each is only meaningful in its own state.
    logic start_acc;
    logic pt_fire;
    logic core_fire;
    logic ct_fire;

    assign start_acc = (state_q == IDLE)      && cfg_start;
    assign pt_fire   = (state_q == GET_PT)    && pt_valid;
    assign core_fire = (state_q == CORE_WAIT) && core_done;
    assign ct_fire   = (state_q == PUT_CT)    && ct_ready;

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    // NOTE: the default assignment at the top keeps this block free of latches
    // on paths that do not change state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (cfg_start) state_d = (cfg_num_blocks == '0) ? FINISH : KEY_LOAD;
            KEY_LOAD:  state_d = KEY_WAIT;
            KEY_WAIT:  if (core_key_ready) state_d = GET_PT;
            GET_PT:    if (pt_valid) state_d = CORE_RUN;
            CORE_RUN:  state_d = CORE_WAIT;
            CORE_WAIT: if (core_done) state_d = PUT_CT;
            PUT_CT:    if (ct_ready) state_d = ct_last_q ? FINISH : GET_PT;
            FINISH:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // Control outputs decode the state register directly, so they change only
    // on clock edges and each single-cycle state gives a single-cycle pulse.
    always_comb begin
        busy          = (state_q != IDLE);
        done          = (state_q == FINISH);
        pt_ready      = (state_q == GET_PT);
        ct_valid      = (state_q == PUT_CT);
        core_key_load = (state_q == KEY_LOAD);
        core_start    = (state_q == CORE_RUN);
    end

    assign core_key   = key_q;
    assign core_block = block_q;
    assign ct_data    = ct_data_q;
    assign ct_last    = ct_last_q;

    // ----------------------------------------------------------------- datapath
    // Data registers are cleared on reset as well so an aborted message leaves
    // nothing of its key, chain or ciphertext visible on the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q     <= '0;
            chain_q   <= '0;
            block_q   <= '0;
            ct_data_q <= '0;
            ct_last_q <= 1'b0;
            num_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (start_acc) begin
                key_q   <= cfg_key;
                chain_q <= cfg_iv;
                num_q   <= cfg_num_blocks;
                cnt_q   <= '0;
            end
            if (pt_fire) begin
                block_q <= pt_data ^ chain_q;
            end
            if (core_fire) begin
                ct_data_q <= core_result;
                chain_q   <= core_result;
                // num_q >= 1 here: a zero-length message never reaches the core.
                ct_last_q <= (cnt_q == num_q - CNT_W'(1));
            end
            if (ct_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule : aes128_cbc_seq_ctrl

// File: tb/tb_aes128_cbc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes128_cbc_seq_ctrl
// Self-checking bench for the CBC sequencer. A behavioural core returns the
// bitwise inverse of its input block five cycles after core_start and raises
// core_key_ready three cycles after core_key_load. Expected core inputs and
// ciphertexts are queued when a message is issued; a monitor pops and compares
// them whenever the DUT presents core_start or a ciphertext handshake.
// -----------------------------------------------------------------------------
module tb_aes128_cbc_seq_ctrl;

    localparam int CNT_W = 16;
    localparam int BLK_W = 128;

    typedef logic [BLK_W-1:0] blk_t;
    typedef struct {
        blk_t data;
        logic last;
    } ct_exp_t;

    logic             clk;
    logic             reset_n;
    logic             cfg_start;
    blk_t             cfg_key;
    blk_t             cfg_iv;
    logic [CNT_W-1:0] cfg_num_blocks;
    logic             busy;
    logic             done;
    blk_t             pt_data;
    logic             pt_valid;
    logic             pt_ready;
    blk_t             ct_data;
    logic             ct_valid;
    logic             ct_ready;
    logic             ct_last;
    blk_t             core_key;
    logic             core_key_load;
    logic             core_key_ready;
    logic             core_start;
    blk_t             core_block;
    logic             core_done;
    blk_t             core_result;

    aes128_cbc_seq_ctrl #(.CNT_W(CNT_W), .BLK_W(BLK_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start      (cfg_start),
        .cfg_key        (cfg_key),
        .cfg_iv         (cfg_iv),
        .cfg_num_blocks (cfg_num_blocks),
        .busy           (busy),
        .done           (done),
        .pt_data        (pt_data),
        .pt_valid       (pt_valid),
        .pt_ready       (pt_ready),
        .ct_data        (ct_data),
        .ct_valid       (ct_valid),
        .ct_ready       (ct_ready),
        .ct_last        (ct_last),
        .core_key       (core_key),
        .core_key_load  (core_key_load),
        .core_key_ready (core_key_ready),
        .core_start     (core_start),
        .core_block     (core_block),
        .core_done      (core_done),
        .core_result    (core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ bookkeeping
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input blk_t act, input blk_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    blk_t    exp_blk_q[$];
    ct_exp_t exp_ct_q[$];

    // ------------------------------------------------------------- core model
    int   core_cnt = 0;
    int   key_cnt  = 0;
    blk_t core_pending;
    logic stray_tog  = 1'b0;
    logic stray_seen = 1'b0;
    blk_t stray_val  = '0;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (!reset_n) begin
            core_cnt       = 0;
            key_cnt        = 0;
            core_key_ready = 1'b0;
            stray_seen     = stray_tog;
        end else begin
            if (core_key_load) begin
                core_key_ready = 1'b0;
                key_cnt        = 3;
            end else if (key_cnt > 0) begin
                key_cnt--;
                if (key_cnt == 0) core_key_ready = 1'b1;
            end
            if (core_start) begin
                core_cnt     = 5;
                core_pending = ~core_block;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_done   = 1'b1;
                    core_result = core_pending;
                end
            end
            if (stray_seen != stray_tog) begin
                stray_seen  = stray_tog;
                core_done   = 1'b1;
                core_result = stray_val;
            end
        end
    end

    // ------------------------------------------------------ ct_ready driver
    int stall_n   = 0;
    int stall_cnt = 0;

    always @(posedge clk) begin
        #2;
        if (!ct_valid) begin
            stall_cnt = 0;
            ct_ready  = (stall_n == 0);
        end else if (stall_cnt < stall_n) begin
            stall_cnt++;
            ct_ready = 1'b0;
        end else begin
            ct_ready = 1'b1;
        end
    end

    // ---------------------------------------------------------------- monitor
    int      starts_seen = 0;
    int      loads_seen  = 0;
    logic    stall_prev  = 1'b0;
    blk_t    stall_data;
    logic    stall_last;
    ct_exp_t got;

    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (core_key_load) loads_seen++;
            if (core_start) begin
                starts_seen++;
                if (exp_blk_q.size() == 0) check_bit("core_start unexpected", 1'b1, 1'b0);
                else check("core_block", core_block, exp_blk_q.pop_front());
            end
            if (ct_valid) begin
                check_bit("pt_ready low while ct_valid", pt_ready, 1'b0);
                if (stall_prev) begin
                    check("ct_data stable in stall", ct_data, stall_data);
                    check_bit("ct_last stable in stall", ct_last, stall_last);
                end
                if (ct_ready) begin
                    stall_prev = 1'b0;
                    if (exp_ct_q.size() == 0) begin
                        check_bit("ct unexpected", 1'b1, 1'b0);
                    end else begin
                        got = exp_ct_q.pop_front();
                        check("ct_data", ct_data, got.data);
                        check_bit("ct_last", ct_last, got.last);
                    end
                end else begin
                    stall_prev = 1'b1;
                    stall_data = ct_data;
                    stall_last = ct_last;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    blk_t pt_tab[0:3];

    task automatic pulse_start(input blk_t key, input blk_t iv, input int num);
        @(negedge clk);
        cfg_key        = key;
        cfg_iv         = iv;
        cfg_num_blocks = CNT_W'(num);
        cfg_start      = 1'b1;
        @(negedge clk);
        cfg_start      = 1'b0;
    endtask

    task automatic send_pt(input blk_t d);
        int t;
        t        = 0;
        pt_data  = d;
        pt_valid = 1'b1;
        @(negedge clk);
        while (!pt_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!pt_ready) check_bit("pt_ready timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        pt_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int t;
        t = 0;
        while (!done && t < lim) begin
            @(negedge clk);
            t++;
        end
        check_bit("done pulse seen", done, 1'b1);
        @(negedge clk);
        check_bit("done single cycle", done, 1'b0);
        check_bit("busy low after done", busy, 1'b0);
    endtask

    task automatic queue_expect(input blk_t iv, input int num);
        blk_t chain;
        blk_t blk;
        chain = iv;
        for (int i = 0; i < num; i++) begin
            blk = pt_tab[i] ^ chain;
            exp_blk_q.push_back(blk);
            exp_ct_q.push_back('{~blk, (i == num - 1)});
            chain = ~blk;
        end
    endtask

    task automatic run_msg(input blk_t key, input blk_t iv, input int num,
                           input int stall, input bit inject);
        stall_n     = stall;
        starts_seen = 0;
        loads_seen  = 0;
        queue_expect(iv, num);
        pulse_start(key, iv, num);
        check_bit("busy after start", busy, 1'b1);
        check("core_key captured", core_key, key);
        if (num == 0) begin
            wait_done(2);
        end else begin
            for (int i = 0; i < num; i++) begin
                send_pt(pt_tab[i]);
                if (inject && i == 0) begin
                    pulse_start(~key, 128'hDEAD_BEEF, 7);
                    check("core_key after ignored start", core_key, key);
                end
            end
            wait_done(3000);
        end
        check_int("core_start count", starts_seen, num);
        check_int("core_key_load count", loads_seen, (num > 0) ? 1 : 0);
        check_int("ct outputs outstanding", exp_ct_q.size(), 0);
        repeat (2) @(negedge clk);
        check_bit("stays idle", busy, 1'b0);
        stall_n = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, " busy"}, busy, 1'b0);
        check_bit({tag, " done"}, done, 1'b0);
        check_bit({tag, " pt_ready"}, pt_ready, 1'b0);
        check_bit({tag, " ct_valid"}, ct_valid, 1'b0);
        check_bit({tag, " ct_last"}, ct_last, 1'b0);
        check_bit({tag, " core_key_load"}, core_key_load, 1'b0);
        check_bit({tag, " core_start"}, core_start, 1'b0);
        check({tag, " ct_data"}, ct_data, '0);
        check({tag, " core_block"}, core_block, '0);
        check({tag, " core_key"}, core_key, '0);
    endtask

    initial begin
        reset_n        = 1'b0;
        cfg_start      = 1'b0;
        cfg_key        = '0;
        cfg_iv         = '0;
        cfg_num_blocks = '0;
        pt_data        = '0;
        pt_valid       = 1'b0;
        ct_ready       = 1'b1;
        core_done      = 1'b0;
        core_result    = '0;
        core_key_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single block.
        pt_tab[0] = 128'h1;
        run_msg(128'h100F0E0D0C0B0A090807060504030201, '0, 1, 0, 1'b0);

        // Two-block chaining with zero plaintext.
        pt_tab[0] = '0;
        pt_tab[1] = '0;
        run_msg(128'hA5A5, 128'h0102030405060708090A0B0C0D0E0F10, 2, 0, 1'b0);

        // Backpressure: ten stalled cycles per ciphertext.
        pt_tab[0] = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        pt_tab[1] = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        pt_tab[2] = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        run_msg(128'h1234, 128'hCAFE_F00D, 3, 10, 1'b0);

        // Zero-length message.
        run_msg(128'h5555, 128'h7777, 0, 0, 1'b0);

        // Start pulse while busy must be ignored.
        pt_tab[0] = 128'h0F0F;
        pt_tab[1] = 128'hF0F0_0000_1111;
        run_msg(128'hBEEF_0001, 128'h3C3C_3C3C, 2, 0, 1'b1);

        // Reset in CORE_WAIT of block 1 of 3.
        pt_tab[0] = 128'h1111;
        pt_tab[1] = 128'h2222;
        pt_tab[2] = 128'h3333;
        starts_seen = 0;
        queue_expect(128'h9999, 3);
        pulse_start(128'h4242, 128'h9999, 3);
        send_pt(pt_tab[0]);
        begin
            int t;
            t = 0;
            while (starts_seen == 0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            check_int("core_start before abort", starts_seen, 1);
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        exp_blk_q.delete();
        exp_ct_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stray_val = 128'hBAD0_BAD0;
        stray_tog = ~stray_tog;
        repeat (4) @(negedge clk);
        check_bit("stray core_done ct_valid", ct_valid, 1'b0);
        check_bit("stray core_done busy", busy, 1'b0);
        check("stray core_done ct_data", ct_data, '0);

        // Fresh message after the abort.
        pt_tab[0] = 128'hABCD;
        pt_tab[1] = 128'h0;
        pt_tab[2] = 128'hFFFF;
        run_msg(128'h6060, 128'h0BAD_F00D_0000_1234, 3, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_aes128_cbc_seq_ctrl
